// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops bytes from the async FIFO read port and packs
// PACK_RATIO of them into one word on a valid/ready stream. A flush request
// drains a partial word with a lane keep mask and out_last set.
//
// Ports:
//   rd_clk, rd_rst_n   read-domain clock, async active-low reset
//   fifo_empty         FIFO empty flag
//   fifo_rd_en         FIFO pop request (combinational)
//   fifo_rd_data       FIFO data, valid the cycle after a pop
//   flush              level request to emit the current partial word
//   out_data/out_keep/out_last/out_valid/out_ready  packed word stream
//   busy               bytes in flight, in the accumulator or in the output
//   byte_cnt           wrapping count of bytes popped since reset
module fifo_rd_packer #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PACK_RATIO = 4,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                             rd_clk,
   input  logic                             rd_rst_n,
   input  logic                             fifo_empty,
   output logic                             fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]            fifo_rd_data,
   input  logic                             flush,
   output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
   output logic [PACK_RATIO-1:0]            out_keep,
   output logic                             out_last,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic                             busy,
   output logic [CNT_WIDTH-1:0]             byte_cnt
);

   localparam int unsigned LANE_W = $clog2(PACK_RATIO);
   localparam int unsigned FILL_W = LANE_W + 1;
   localparam int unsigned OCC_W  = FILL_W + 1;
   localparam int unsigned WORD_W = DATA_WIDTH * PACK_RATIO;

   typedef enum logic [1:0] {
      IDLE          = 2'd0,
      WAIT_INFLIGHT = 2'd1,
      EMIT          = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [FILL_W-1:0]     fill_q, fill_d, fill_eff;
   logic [OCC_W-1:0]      occ_next;
   logic                  inflight_q;
   logic [WORD_W-1:0]     acc_q, acc_d;
   logic [WORD_W-1:0]     out_data_d;
   logic [PACK_RATIO-1:0] out_keep_d;
   logic                  out_last_d, out_valid_d;
   logic                  out_free, xfer;

   // Next-state, pop request, capture and output-load decisions
   always_comb begin
      state_d     = state_q;
      fill_d      = fill_q;
      acc_d       = acc_q;
      out_data_d  = out_data;
      out_keep_d  = out_keep;
      out_last_d  = out_last;
      out_valid_d = out_valid;

      out_free = !out_valid || out_ready;
      xfer     = (state_q == IDLE) && (fill_q == FILL_W'(PACK_RATIO)) && out_free;
      // Lanes occupied once this cycle's full-word transfer (if any) is done
      fill_eff = xfer ? '0 : fill_q;
      occ_next = OCC_W'(fill_eff) + OCC_W'(inflight_q);

      // A pop that would land on a full accumulator is still safe when the
      // output register is guaranteed free next cycle: that cycle transfers
      // the full word and captures the new byte into lane 0 (zero bubble).
      fifo_rd_en = !fifo_empty && (state_q == IDLE) &&
                   ((occ_next < OCC_W'(PACK_RATIO)) ||
                    ((occ_next == OCC_W'(PACK_RATIO)) && !flush && out_free));

      if (out_valid && out_ready) out_valid_d = 1'b0;

      if (xfer) begin
         out_data_d  = acc_q;
         out_keep_d  = '1;
         out_last_d  = 1'b0;
         out_valid_d = 1'b1;
      end

      if (inflight_q)
         acc_d[int'(fill_eff[LANE_W-1:0])*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data;
      fill_d = fill_eff + FILL_W'(inflight_q);

      case (state_q)
         IDLE: begin
            if (flush && ((fill_eff != '0) || inflight_q)) state_d = WAIT_INFLIGHT;
         end
         WAIT_INFLIGHT: begin
            if (!inflight_q) state_d = EMIT;
         end
         EMIT: begin
            if (out_free) begin
               out_data_d = '0;
               out_keep_d = '0;
               for (int unsigned i = 0; i < PACK_RATIO; i++) begin
                  if (FILL_W'(i) < fill_q) begin
                     out_keep_d[i] = 1'b1;
                     out_data_d[i*DATA_WIDTH +: DATA_WIDTH] = acc_q[i*DATA_WIDTH +: DATA_WIDTH];
                  end
               end
               out_last_d  = 1'b1;
               out_valid_d = 1'b1;
               fill_d      = '0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         state_q    <= IDLE;
         fill_q     <= '0;
         inflight_q <= 1'b0;
         acc_q      <= '0;
         out_data   <= '0;
         out_keep   <= '0;
         out_last   <= 1'b0;
         out_valid  <= 1'b0;
         byte_cnt   <= '0;
      end else begin
         state_q    <= state_d;
         fill_q     <= fill_d;
         inflight_q <= fifo_rd_en;
         acc_q      <= acc_d;
         out_data   <= out_data_d;
         out_keep   <= out_keep_d;
         out_last   <= out_last_d;
         out_valid  <= out_valid_d;
         if (fifo_rd_en) byte_cnt <= byte_cnt + CNT_WIDTH'(1);
      end
   end

   assign busy = inflight_q | (fill_q != '0) | out_valid | (state_q != IDLE);

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a queue-backed FIFO model feeds the DUT, a byte
// list model predicts packed words into a scoreboard, and a monitor checks
// every output handshake and output stability under backpressure.
module tb_fifo_rd_packer;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } word_t;

   logic        rd_clk = 1'b0;
   logic        rd_rst_n = 1'b0;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [7:0]  fifo_rd_data = 8'h00;
   logic        flush = 1'b0;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic        out_last;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        busy;
   logic [15:0] byte_cnt;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0]  fmem [0:1023];
   int unsigned wr_ptr = 0;
   int unsigned rd_ptr = 0;

   logic [7:0] mb[$];
   word_t      sb[$];
   int         hs_cyc[$];
   int         pushed_total = 0;

   fifo_rd_packer #(.DATA_WIDTH(8), .PACK_RATIO(4), .CNT_WIDTH(16)) dut (
      .rd_clk(rd_clk), .rd_rst_n(rd_rst_n),
      .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
      .flush(flush),
      .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .byte_cnt(byte_cnt)
   );

   always #5 rd_clk = ~rd_clk;

   assign fifo_empty = (wr_ptr == rd_ptr);

   // FIFO read side: data appears the cycle after an accepted pop
   always @(posedge rd_clk) begin
      cyc <= cyc + 1;
      if (fifo_rd_en && !fifo_empty) begin
         fifo_rd_data <= fmem[rd_ptr % 1024];
         rd_ptr       <= rd_ptr + 1;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference model: bytes queue up in pop order; every 4 make a full word
   function automatic word_t make_word(input int n, input logic last);
      word_t w;
      w.data = '0;
      w.keep = '0;
      w.last = last;
      for (int i = 0; i < n; i++) begin
         w.data[8*i +: 8] = mb[i];
         w.keep[i]        = 1'b1;
      end
      return w;
   endfunction

   task automatic push_raw(input logic [7:0] b);
      fmem[wr_ptr % 1024] = b;
      wr_ptr = wr_ptr + 1;
      pushed_total++;
   endtask

   task automatic push_byte(input logic [7:0] b);
      push_raw(b);
      mb.push_back(b);
      if (mb.size() == 4) begin
         sb.push_back(make_word(4, 1'b0));
         mb.delete();
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge rd_clk);
      #1;
   endtask

   task automatic settle();
      int t = 0;
      out_ready = 1'b1;
      while ((sb.size() != 0 || !fifo_empty) && t < 400) begin
         tick(1);
         t++;
      end
      chk("settle_timeout", 64'(t >= 400), 64'(0));
      tick(3);
   endtask

   task automatic do_flush();
      if (mb.size() != 0) begin
         sb.push_back(make_word(mb.size(), 1'b1));
         mb.delete();
      end
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
   endtask

   // Monitor: compares every handshake against the scoreboard
   initial begin : monitor
      word_t held;
      logic  hold_v;
      word_t e;
      hold_v = 1'b0;
      held   = '0;
      forever begin
         @(negedge rd_clk);
         if (!rd_rst_n) begin
            hold_v = 1'b0;
         end else begin
            if (fifo_rd_en) chk("rd_en_while_empty", 64'(fifo_empty), 64'(0));
            if (out_valid) begin
               if (hold_v) begin
                  chk("hold_data", 64'(out_data), 64'(held.data));
                  chk("hold_keep", 64'(out_keep), 64'(held.keep));
                  chk("hold_last", 64'(out_last), 64'(held.last));
               end
               if (out_ready) begin
                  hs_cyc.push_back(cyc);
                  hold_v = 1'b0;
                  checks++;
                  if (sb.size() == 0) begin
                     errors++;
                     $display("FAIL unexpected_word actual=%0h/%0h/%0b expected=none",
                              out_data, out_keep, out_last);
                  end else begin
                     e = sb.pop_front();
                     if (out_data !== e.data || out_keep !== e.keep || out_last !== e.last) begin
                        errors++;
                        $display("FAIL word actual=%0h/%0h/%0b expected=%0h/%0h/%0b",
                                 out_data, out_keep, out_last, e.data, e.keep, e.last);
                     end
                  end
               end else begin
                  hold_v = 1'b1;
                  held   = '{data: out_data, keep: out_keep, last: out_last};
               end
            end else begin
               hold_v = 1'b0;
            end
         end
      end
   end

   initial begin : stim
      int unsigned p0;
      int          n;
      int          k;

      // Reset state
      tick(3);
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_last",  64'(out_last),  64'(0));
      chk("rst_busy",      64'(busy),      64'(0));
      chk("rst_rd_en",     64'(fifo_rd_en), 64'(0));
      chk("rst_out_data",  64'(out_data),  64'(0));
      chk("rst_out_keep",  64'(out_keep),  64'(0));
      chk("rst_byte_cnt",  64'(byte_cnt),  64'(0));
      rd_rst_n = 1'b1;
      tick(2);
      chk("idle_busy", 64'(busy), 64'(0));

      // Single full word
      out_ready = 1'b1;
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
      settle();
      chk("cnt_after_word", 64'(byte_cnt), 64'(4));

      // Streaming throughput: one word every 4 cycles
      hs_cyc.delete();
      for (int i = 1; i <= 12; i++) push_byte(8'(i));
      settle();
      chk("stream_words", 64'(hs_cyc.size()), 64'(3));
      if (hs_cyc.size() == 3) begin
         chk("stream_gap1", 64'(hs_cyc[1] - hs_cyc[0]), 64'(4));
         chk("stream_gap2", 64'(hs_cyc[2] - hs_cyc[1]), 64'(4));
      end
      chk("cnt_after_stream", 64'(byte_cnt), 64'(16));

      // Backpressure: popping stops after 8 bytes with output blocked
      out_ready = 1'b0;
      p0 = rd_ptr;
      for (int i = 1; i <= 12; i++) push_byte(8'(i));
      tick(30);
      chk("bp_pops", 64'(rd_ptr - p0), 64'(8));
      chk("bp_valid", 64'(out_valid), 64'(1));
      settle();
      chk("bp_sb_empty", 64'(sb.size()), 64'(0));
      chk("cnt_after_bp", 64'(byte_cnt), 64'(28));

      // Flush with the second byte in flight
      push_byte(8'hAA); push_byte(8'hBB);
      tick(2);
      do_flush();
      settle();
      chk("flush_busy", 64'(busy), 64'(0));

      // Flush with nothing to drain
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("noop_busy", 64'(busy), 64'(0));
         chk("noop_valid", 64'(out_valid), 64'(0));
         tick(1);
      end

      // Reset mid-word discards the partial accumulator
      push_raw(8'hE1); push_raw(8'hE2);
      tick(5);
      rd_rst_n = 1'b0;
      tick(2);
      chk("midrst_cnt", 64'(byte_cnt), 64'(0));
      mb.delete();
      sb.delete();
      pushed_total = 0;
      rd_rst_n = 1'b1;
      tick(1);
      push_byte(8'h55); push_byte(8'h66); push_byte(8'h77); push_byte(8'h88);
      settle();
      chk("midrst_cnt_after", 64'(byte_cnt), 64'(4));

      // Randomized traffic with random backpressure and flushes
      for (int r = 0; r < 10; r++) begin
         n = int'($urandom_range(1, 20));
         k = 0;
         while (k < n) begin
            out_ready = ($urandom % 4) != 0;
            if ($urandom % 2 == 1) begin
               push_byte(8'($urandom));
               k++;
            end
            tick(1);
         end
         settle();
         if (mb.size() != 0 && ($urandom % 2 == 1)) begin
            out_ready = ($urandom % 2) != 0;
            do_flush();
            settle();
         end
      end
      do_flush();
      settle();
      chk("rand_sb_empty", 64'(sb.size()), 64'(0));
      chk("rand_cnt", 64'(byte_cnt), 64'(16'(pushed_total)));
      chk("rand_busy", 64'(busy), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-domain stage directly downstream of the asynchronous FIFO.
- Pops bytes through the FIFO's empty/rd_en/rd_data read port and packs PACK_RATIO consecutive bytes into one wide word.
- Presents each word on a valid/ready stream.
- A flush request drains a partial word with a byte-keep mask, so trailing bytes are never stranded.

Parameters:
- DATA_WIDTH, 8: FIFO byte width; must equal the FIFO's DATA_WIDTH.
- PACK_RATIO, 4: bytes per output word; power of two, 2..16.
- CNT_WIDTH, 16: width of the popped-byte statistics counter.

Ports:
- rd_clk  input  1  read-domain clock, shared with the FIFO read side.
- rd_rst_n  input  1  asynchronous active-low reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  FIFO pop request.
- fifo_rd_data  input  DATA_WIDTH  FIFO read data; valid the cycle after an accepted pop.
- flush  input  1  level request to emit the current partial word.
- out_data  output  DATA_WIDTH*PACK_RATIO  packed word; lane 0 = first-popped byte.
- out_keep  output  PACK_RATIO  per-lane valid mask.
- out_last  output  1  word was produced by a flush.
- out_valid  output  1  out_data/out_keep/out_last valid.
- out_ready  input  1  downstream accept.
- busy  output  1  any byte in flight, in the accumulator or in the output register.
- byte_cnt  output  CNT_WIDTH  total bytes popped since reset; wraps.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - out_valid, out_last, fifo_rd_en and busy are 0.
  - out_data, out_keep, byte_cnt, fill_cnt and inflight are 0.
- Pop rule: fifo_rd_en = !fifo_empty && (fill_cnt + inflight < PACK_RATIO) && !flush_pend.
  - fifo_rd_en is combinational; never asserted while fifo_empty=1.
  - inflight is a 1-bit register set on the pop cycle and cleared on the capture cycle.
- Capture: in the cycle after a pop, fifo_rd_data is written to lane fill_cnt of the accumulator, and fill_cnt increments.
  - byte_cnt increments on every pop and wraps to 0 at 2^CNT_WIDTH.
- Word transfer: when fill_cnt == PACK_RATIO and the output register is free, the accumulator moves to the output register.
  - Free means out_valid=0, or out_valid && out_ready in the same cycle.
  - On transfer: out_keep is all ones, out_last=0, fill_cnt returns to 0.
  - Zero-bubble: a transfer and a capture into lane 0 may occur in the same cycle.
- Backpressure:
  - out_data, out_keep and out_last are held stable while out_valid && !out_ready.
  - While the accumulator is full and the output register is blocked, popping stops by the pop rule. No data is lost.
- Throughput: one word per PACK_RATIO cycles at steady state with out_ready=1 and the FIFO non-empty.
- Flush state machine, states IDLE -> WAIT_INFLIGHT -> EMIT -> IDLE:
  - IDLE: flush=1 with fill_cnt>0 or inflight=1 sets flush_pend; go to WAIT_INFLIGHT.
  - IDLE: flush=1 with fill_cnt=0, inflight=0 and a free output register is a no-op; stay in IDLE.
  - WAIT_INFLIGHT: no new pops; wait for inflight=0, then go to EMIT.
  - EMIT: when the output register is free, load the accumulator.
    - out_keep = (1<<fill_cnt)-1; unused lanes are 0; out_last=1.
    - Clear fill_cnt and flush_pend; go to IDLE.
  - flush is ignored outside IDLE; a flush held high re-arms only after returning to IDLE.
  - If fill_cnt reaches PACK_RATIO during WAIT_INFLIGHT, the word emits with keep all ones and out_last=1.
- busy = inflight | (fill_cnt!=0) | out_valid | flush_pend.
- Reset mid-operation: all accumulator contents, in-flight bytes and the pending output word are discarded; the state machine returns to IDLE.

Test Plan:
- Push bytes 0x11,0x22,0x33,0x44 into the FIFO, out_ready=1 -> one word: out_data=0x44332211, out_keep=4'b1111, out_last=0; byte_cnt=4.
- Push 12 bytes 0x01..0x0C with out_ready=1 -> words 0x04030201, 0x08070605, 0x0C0B0A09, one every 4 cycles once streaming; no bubbles.
- Hold out_ready=0 and push 0x01..0x0C -> fifo_rd_en stops after 8 pops, first word held stable. Release out_ready -> all 3 words delivered in order, none lost or duplicated.
- Push 0xAA,0xBB, then pulse flush while the second byte is in flight -> out_data=0x0000BBAA, out_keep=4'b0011, out_last=1; busy drops to 0 after the handshake.
- Flush with an empty accumulator and nothing in flight -> no word emitted, busy stays 0.
- Pop 2 bytes, assert rd_rst_n=0 mid-word, release, then push 0x55,0x66,0x77,0x88 -> only 0x88776655 emitted; byte_cnt=4 after the reset.
